// File: rtl/result_writeback_ctrl_pkg.sv
// result_writeback_ctrl_pkg: write-back FSM states and image/packing geometry helpers
package result_writeback_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} wb_state_e;
  function automatic int ppw(input int word, input int pixel);
    return word / pixel;
  endfunction
  function automatic int total_pix(input int out_size);
    return out_size * out_size;
  endfunction
  function automatic int total_words(input int out_size, input int word, input int pixel);
    return (total_pix(out_size) + ppw(word, pixel) - 1) / ppw(word, pixel);
  endfunction
  function automatic int cnt_w(input int n);
    return n < 1 ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/wb_sync_fifo.sv
// wb_sync_fifo: single-clock show-ahead FIFO; a push on a full FIFO is taken only with a same-edge pop
module wb_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem_q[rd_q];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/result_writeback_ctrl.sv
// result_writeback_ctrl: packs result pixels into words, queues them and writes them to memory
module result_writeback_ctrl
  import result_writeback_ctrl_pkg::*;
#(
  parameter int EADDR = 32,
  parameter int PIXEL = 8,
  parameter int WORD = 32,
  parameter int OUT_SIZE = 508,
  parameter int FIFO_DEPTH = 16,
  parameter logic [EADDR-1:0] BASE_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             allow,
  input  logic [PIXEL-1:0] pix,
  output logic [EADDR-1:0] E_MEM_ADDR,
  output logic [WORD-1:0]  data_out,
  output logic             we,
  input  logic             mem_ready,
  output logic             busy,
  output logic             overflow,
  output logic             complete
);
  localparam int PPW = ppw(WORD, PIXEL);
  localparam int TOTAL_PIX = total_pix(OUT_SIZE);
  localparam int TOTAL_WORDS = total_words(OUT_SIZE, WORD, PIXEL);
  localparam int PW = cnt_w(TOTAL_PIX);
  localparam int WW = cnt_w(TOTAL_WORDS);
  localparam int LW = PPW > 1 ? $clog2(PPW) : 1;
  wb_state_e state_q;
  logic [PW-1:0] pix_cnt_q;
  logic [LW-1:0] lane_q;
  logic [WORD-1:0] packer_q, merged, push_data, fifo_dout, data_q;
  logic [WW-1:0] word_idx_q;
  logic [EADDR-1:0] addr_q;
  logic overflow_q, we_q, busy_q, complete_q;
  logic accept, word_done, last_pix, push, pop, fire, drop, full, empty;
  assign E_MEM_ADDR = addr_q;
  assign data_out = data_q;
  assign we = we_q;
  assign busy = busy_q;
  assign overflow = overflow_q;
  assign complete = complete_q;
  always_comb begin
    accept = state_q == RUN && allow;
    merged = packer_q | (WORD'(pix) << (lane_q * PIXEL));
    word_done = accept && lane_q == LW'(PPW - 1);
    last_pix = accept && pix_cnt_q == PW'(TOTAL_PIX - 1);
    fire = we_q && mem_ready;
    pop = !empty && (!we_q || mem_ready);
    push = word_done || (state_q == FLUSH && (!full || pop));
    push_data = state_q == FLUSH ? packer_q : merged;
    drop = word_done && full && !pop;
  end
  wb_sync_fifo #(.WIDTH(WORD), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(push_data),
    .full(full), .empty(empty), .dout(fifo_dout)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pix_cnt_q <= '0;
      lane_q <= '0;
      packer_q <= '0;
      word_idx_q <= '0;
      overflow_q <= 1'b0;
      busy_q <= 1'b0;
      complete_q <= 1'b0;
    end else if ((state_q == IDLE || state_q == DONE) && start) begin
      state_q <= RUN;
      pix_cnt_q <= '0;
      lane_q <= '0;
      packer_q <= '0;
      word_idx_q <= '0;
      overflow_q <= 1'b0;
      busy_q <= 1'b1;
      complete_q <= 1'b0;
    end else begin
      if (accept) begin
        pix_cnt_q <= pix_cnt_q + 1'b1;
        lane_q <= word_done ? '0 : lane_q + 1'b1;
        packer_q <= word_done ? '0 : merged;
      end
      if (last_pix) state_q <= word_done ? DRAIN : FLUSH;
      if (state_q == FLUSH && push) begin
        state_q <= DRAIN;
        packer_q <= '0;
      end
      // word_idx counts only accepted writes, so a dropped word keeps the frame from completing
      if (state_q == DRAIN && word_idx_q == WW'(TOTAL_WORDS) && empty) begin
        state_q <= DONE;
        busy_q <= 1'b0;
        complete_q <= 1'b1;
      end
      if (drop) overflow_q <= 1'b1;
      if (fire) word_idx_q <= word_idx_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      data_q <= '0;
      addr_q <= '0;
    end else if (pop) begin
      we_q <= 1'b1;
      data_q <= fifo_dout;
      addr_q <= BASE_ADDR + EADDR'(word_idx_q) + EADDR'(fire);
    end else if (fire) begin
      we_q <= 1'b0;
    end
  end
endmodule
